// File: rtl/pcs64b66b_pkg.sv
// ---------------------------------------------------------------------------
// pcs64b66b_pkg
// Shared definitions for the 64b/66b receive path: the block-lock state
// encoding, the two legal sync-header patterns and the default lock/BER
// constants used by block_lock_ctrl and its neighbours.
// ---------------------------------------------------------------------------
package pcs64b66b_pkg;

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } lock_state_t;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int DEF_LOCK_CNT  = 64;
  localparam int DEF_WIN_LEN   = 64;
  localparam int DEF_BAD_LIMIT = 16;
  localparam int DEF_SLIP_WAIT = 2;
  localparam int DEF_BER_TIMER = 19531;
  localparam int DEF_BER_LIMIT = 16;

  localparam int ERR_CNT_W = 16;

  // The aligner forms hdr_ok with this helper so both ends agree on which
  // sync-header patterns count as valid.
  function automatic logic sh_is_ok(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/ber_monitor.sv
// ---------------------------------------------------------------------------
// ber_monitor
// High bit-error-rate detector. While enabled it runs a free-running window
// timer and counts bad headers inside each window; reaching the limit raises
// hi_ber at once, and a window that ends below the limit clears it.
// Ports:
//   clk_i      sole clock
//   reset_i    synchronous active-high reset
//   enable_i   monitor active (block lock held); low forces everything to 0
//   hdr_bad_i  a valid header with a bad sync pattern this cycle
//   hi_ber_o   registered high-BER flag
// ---------------------------------------------------------------------------
module ber_monitor #(
  parameter int BER_TIMER = 19531,
  parameter int BER_LIMIT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic hdr_bad_i,
  output logic hi_ber_o
);

  localparam int TMR_W = $clog2(BER_TIMER + 1);
  localparam int CNT_W = $clog2(BER_LIMIT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BER_TIMER - 1);
  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(BER_LIMIT);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] ber_cnt_q, ber_cnt_d;
  logic             hi_ber_q, hi_ber_d;
  logic             wrap;

  assign wrap = (timer_q == TMR_LAST);

  // A bad header on the wrap cycle belongs to the new window, so the count
  // restarts at 1 instead of 0. hi_ber only clears at a wrap whose window
  // stayed below the limit; a saturated count keeps it set into the next
  // window until that one also ends clean.
  always_comb begin
    timer_d   = wrap ? '0 : timer_q + TMR_W'(1);
    ber_cnt_d = ber_cnt_q;
    hi_ber_d  = hi_ber_q;
    if (wrap) begin
      ber_cnt_d = CNT_W'(hdr_bad_i);
      if (ber_cnt_q < CNT_LIM) begin
        hi_ber_d = 1'b0;
      end
    end else if (hdr_bad_i && (ber_cnt_q != CNT_LIM)) begin
      ber_cnt_d = ber_cnt_q + CNT_W'(1);
    end
    if (hdr_bad_i && (ber_cnt_d == CNT_LIM)) begin
      hi_ber_d = 1'b1;
    end
  end

  // Outside lock the whole monitor is parked at zero so a fresh lock always
  // starts a clean window.
  always_ff @(posedge clk_i) begin
    if (reset_i || !enable_i) begin
      timer_q   <= '0;
      ber_cnt_q <= '0;
      hi_ber_q  <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      ber_cnt_q <= ber_cnt_d;
      hi_ber_q  <= hi_ber_d;
    end
  end

  assign hi_ber_o = hi_ber_q;

endmodule

// File: rtl/block_lock_ctrl.sv
// ---------------------------------------------------------------------------
// block_lock_ctrl
// Block-lock and BER controller for the 64b/66b receive path. Hunts for
// LOCK_CNT consecutive good sync headers, slipping the aligner one bit on
// every bad one, then watches for lock loss (BAD_LIMIT bad headers within a
// WIN_LEN-header window) and high BER while locked.
// Ports:
//   clk         sole clock
//   reset       synchronous active-high reset
//   hdr_valid   a candidate header is evaluated this cycle
//   hdr_ok      header is a legal sync pattern (qualified by hdr_valid)
//   cnt_clear   clears err_cnt
//   slip        one-cycle pulse: aligner advances its bit offset by one
//   block_lock  lock achieved
//   hi_ber      high bit-error rate while locked
//   err_cnt     saturating count of bad headers seen while locked
// ---------------------------------------------------------------------------
module block_lock_ctrl
  import pcs64b66b_pkg::*;
#(
  parameter int LOCK_CNT  = DEF_LOCK_CNT,
  parameter int WIN_LEN   = DEF_WIN_LEN,
  parameter int BAD_LIMIT = DEF_BAD_LIMIT,
  parameter int SLIP_WAIT = DEF_SLIP_WAIT,
  parameter int BER_TIMER = DEF_BER_TIMER,
  parameter int BER_LIMIT = DEF_BER_LIMIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hdr_valid,
  input  logic                 hdr_ok,
  input  logic                 cnt_clear,
  output logic                 slip,
  output logic                 block_lock,
  output logic                 hi_ber,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int SH_W  = $clog2(LOCK_CNT + 1);
  localparam int SW_W  = $clog2(SLIP_WAIT + 1);
  localparam int WIN_W = $clog2(WIN_LEN + 1);
  localparam int BAD_W = $clog2(BAD_LIMIT + 1);
  localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(LOCK_CNT - 1);
  localparam logic [SW_W-1:0]  SW_LAST  = SW_W'(SLIP_WAIT - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(BAD_LIMIT - 1);

  lock_state_t          state_q, state_d;
  logic [SH_W-1:0]      sh_cnt_q, sh_cnt_d;
  logic [SW_W-1:0]      sw_cnt_q, sw_cnt_d;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic [BAD_W-1:0]     bad_cnt_q, bad_cnt_d;
  logic                 slip_q, slip_d;
  logic                 lock_q;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 hdr_bad;
  logic                 err_inc;

  assign hdr_bad = hdr_valid & ~hdr_ok;
  assign err_inc = hdr_bad & (state_q == ST_LOCKED);

  // Lock state machine. Only valid headers move it; idle cycles leave every
  // header counter untouched. In LOCKED a bad header that hits the limit is
  // checked before the end-of-window clear, so lock loss wins when both
  // happen on the last header of a window.
  always_comb begin
    state_d   = state_q;
    sh_cnt_d  = sh_cnt_q;
    sw_cnt_d  = sw_cnt_q;
    win_cnt_d = win_cnt_q;
    bad_cnt_d = bad_cnt_q;
    slip_d    = 1'b0;
    if (hdr_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (!hdr_ok) begin
            slip_d   = 1'b1;
            sh_cnt_d = '0;
            sw_cnt_d = '0;
            state_d  = ST_SLIP_WAIT;
          end else if (sh_cnt_q == SH_LAST) begin
            sh_cnt_d  = '0;
            win_cnt_d = '0;
            bad_cnt_d = '0;
            state_d   = ST_LOCKED;
          end else begin
            sh_cnt_d = sh_cnt_q + SH_W'(1);
          end
        end
        ST_SLIP_WAIT: begin
          if (sw_cnt_q == SW_LAST) begin
            sw_cnt_d = '0;
            sh_cnt_d = '0;
            state_d  = ST_HUNT;
          end else begin
            sw_cnt_d = sw_cnt_q + SW_W'(1);
          end
        end
        ST_LOCKED: begin
          if (!hdr_ok && (bad_cnt_q == BAD_LAST)) begin
            slip_d   = 1'b1;
            sw_cnt_d = '0;
            state_d  = ST_SLIP_WAIT;
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            bad_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            if (!hdr_ok) begin
              bad_cnt_d = bad_cnt_q + BAD_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  // Error counter: clear takes priority but still counts a bad header that
  // arrives in the same cycle, so no error is ever lost.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cnt_clear) begin
      err_cnt_d = ERR_CNT_W'(err_inc);
    end else if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // State and output registers. block_lock is registered from the next
  // state so it always mirrors LOCKED exactly one cycle after the deciding
  // header, and falls together with the lock-loss slip pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_HUNT;
      sh_cnt_q  <= '0;
      sw_cnt_q  <= '0;
      win_cnt_q <= '0;
      bad_cnt_q <= '0;
      slip_q    <= 1'b0;
      lock_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sh_cnt_q  <= sh_cnt_d;
      sw_cnt_q  <= sw_cnt_d;
      win_cnt_q <= win_cnt_d;
      bad_cnt_q <= bad_cnt_d;
      slip_q    <= slip_d;
      lock_q    <= (state_d == ST_LOCKED);
      err_cnt_q <= err_cnt_d;
    end
  end

  ber_monitor #(
    .BER_TIMER(BER_TIMER),
    .BER_LIMIT(BER_LIMIT)
  ) u_ber_monitor (
    .clk_i    (clk),
    .reset_i  (reset),
    .enable_i (lock_q),
    .hdr_bad_i(hdr_bad),
    .hi_ber_o (hi_ber)
  );

  assign slip       = slip_q;
  assign block_lock = lock_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: doc/block_lock_ctrl.md
# block_lock_ctrl

Block-lock and bit-error-rate controller for the 64b/66b receive path. It judges the 2-bit sync header of each candidate block presented by the bit-aligning datapath. It issues one-bit slip commands until 64 consecutive valid headers are seen, then monitors lock loss (16 bad headers in a 64-header window) and high BER (16 bad headers in a timer window). It sits beside the aligner and gates downstream decode via `block_lock`.

## Interface
- `LOCK_CNT`, 64: consecutive good headers required to declare lock.
- `WIN_LEN`, 64: header window length while locked.
- `BAD_LIMIT`, 16: bad headers within `WIN_LEN` that drop lock.
- `SLIP_WAIT`, 2: headers ignored after each slip (aligner pipeline flush); must be ≥1.
- `BER_TIMER`, 19531: BER window length in `clk` cycles (125 µs at 156.25 MHz).
- `BER_LIMIT`, 16: bad headers within a BER window that set `hi_ber`.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `hdr_valid`  in  1  a candidate block's header is evaluated this cycle.
- `hdr_ok`  in  1  header is 2'b01 or 2'b10; qualified by `hdr_valid`.
- `cnt_clear`  in  1  clears `err_cnt`.
- `slip`  out  1  one-cycle pulse; aligner advances its bit offset by one (wrapping 65→0 is the aligner's job).
- `block_lock`  out  1  lock achieved.
- `hi_ber`  out  1  high bit-error rate while locked.
- `err_cnt`  out  16  saturating count of bad headers seen while locked.

## Operation
- States: `HUNT`, `SLIP_WAIT`, `LOCKED`. Reset → `HUNT`.
- **HUNT**
  - Each valid+ok header increments `sh_cnt`.
  - Valid+bad header: pulse `slip`, clear `sh_cnt`, go to `SLIP_WAIT`.
  - Valid+ok when `sh_cnt == LOCK_CNT-1`: go to `LOCKED`, clear the window counters.
- **SLIP_WAIT**
  - Count `SLIP_WAIT` valid headers, ignoring their `hdr_ok`, then return to `HUNT` with `sh_cnt` = 0.
- **LOCKED**
  - `win_cnt` counts valid headers; `bad_cnt` counts valid bad headers.
  - Bad header making `bad_cnt == BAD_LIMIT`: pulse `slip`, go to `SLIP_WAIT`; `block_lock` falls.
  - Header completing the window (`win_cnt == WIN_LEN-1`) without reaching the limit: clear both counters, stay `LOCKED`.
  - Limit reached on the final header of a window: lock loss wins.
- **BER monitor**
  - Active only in `LOCKED`. Otherwise the timer, `ber_cnt` and `hi_ber` are held at 0.
  - Timer counts cycles 0..`BER_TIMER-1` and wraps.
  - A bad header making `ber_cnt == BER_LIMIT` sets `hi_ber` immediately.
  - At wrap: if `ber_cnt < BER_LIMIT`, `hi_ber` clears. `ber_cnt` restarts at 0, or at 1 if a bad header arrives on the wrap cycle.
  - `ber_cnt` saturates at `BER_LIMIT`.
- **Error counter**
  - `err_cnt` increments on each valid bad header while `LOCKED`, saturating at 16'hFFFF.
  - `cnt_clear` with a simultaneous increment yields 1.
- Counter widths are `$clog2(param+1)`. All comparisons are unsigned.

## Timing
- All outputs are registered.
- Reset values: `slip` 0, `block_lock` 0, `hi_ber` 0, `err_cnt` 0, state `HUNT`, all internal counters 0.
- `slip` is high for exactly the cycle after the triggering `hdr_valid` cycle. The next slip cannot be issued until `SLIP_WAIT` further valid headers have been consumed.
- `block_lock` rises the cycle after the `LOCK_CNT`-th consecutive good header. It falls the cycle after the lock-losing header, coincident with `slip`.
- `hi_ber` rises the cycle after the `BER_LIMIT`-th bad header, and clears the cycle after a qualifying timer wrap.
- `hdr_ok` is ignored when `hdr_valid` = 0. Idle cycles never advance the header counters but do advance the BER timer.
- `reset` mid-operation forces reset values on the next edge, including dropping any pending `slip`.

## Structure
- Shared package `pcs64b66b_pkg`:
  - state enum `lock_state_t`;
  - constants `SH_DATA` = 2'b01 and `SH_CTRL` = 2'b10, used by the aligner to form `hdr_ok`;
  - default lock/BER constants.
- Natural sub-module `ber_monitor`, containing the timer, `ber_cnt` and `hi_ber`, enabled by `block_lock`.
- Expected size: about 200 lines of RTL.

## Test plan
- **Lock acquisition:** reset, then 64 good headers → `block_lock`=1 the cycle after header 64. 63 good headers → no lock.
- **Slip on bad header in HUNT:** 10 good, 1 bad → `slip` pulse next cycle. Then 2 ignored bad headers produce no slip, followed by 64 good → lock.
- **Lock loss:** locked, then 15 bad spread within one 64-window → lock held, window resets. 16 bad within a window → `block_lock`=0 and `slip`=1 on the same cycle.
- **High BER:** locked with `BER_TIMER`=100, inject 16 bad within 100 cycles (window limit raised) → `hi_ber`=1. A following clean window → `hi_ber`=0 after wrap.
- **Error counter:** 5 bad while locked → `err_cnt`=5. `cnt_clear` together with a bad header → 1. Preload via 65535 bad → saturates at 65535.
- **Reset mid-slip:** assert `reset` on the cycle `slip` would fire → all outputs 0 next cycle, state `HUNT`.
